hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter MD_CYCLES, default 32: execute cycles of a mult/div before HI/LO are valid; legal range 2..63.
REQ-002 Clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ID_rs  input  5  source register rs of the instruction in ID.
REQ-005 ID_rt  input  5  source register rt of the instruction in ID.
REQ-006 ID_usesRt  input  1  ID instruction reads rt as a source.
REQ-007 ID_isMD  input  1  ID instruction is mult/multu/div/divu.
REQ-008 ID_readsHiLo  input  1  ID instruction is mfhi/mflo.
REQ-009 EX_rd  input  5  destination register of the instruction in EX.
REQ-010 EX_regWrite  input  1  EX instruction writes the register file.
REQ-011 EX_memRead  input  1  EX instruction is a load.
REQ-012 MEM_rd  input  5  destination register of the instruction in MEM.
REQ-013 MEM_regWrite  input  1  MEM instruction writes the register file.
REQ-014 EX_branchTaken  input  1  branch or jump resolved taken in EX.
REQ-015 Stall  output  1  hold PC and IF/ID this cycle.
REQ-016 Flush_IFID  output  1  replace IF/ID contents with a nop at the next edge.
REQ-017 Bubble_IDEX  output  1  load a nop into ID/EX at the next edge.
REQ-018 MD_busy  output  1  mult/div in progress; HI/LO not yet valid.

Function
REQ-019 FSM states: RUN and MD_WAIT; Stall, Flush_IFID and Bubble_IDEX are combinational from state, counter and inputs; MD_busy is registered.
REQ-020 Register 0 never creates a hazard: any match on rd==0 is ignored.
REQ-021 Load-use hazard: EX_memRead & EX_regWrite & EX_rd!=0 & (EX_rd==ID_rs | (ID_usesRt & EX_rd==ID_rt)).
REQ-022 HI/LO hazard: MD_busy & (ID_readsHiLo | ID_isMD).
REQ-023 Any hazard (REQ-021, REQ-022, REQ-036) with EX_branchTaken=0 -> Stall=1, Bubble_IDEX=1, Flush_IFID=0.
REQ-024 EX_branchTaken=1 -> Flush_IFID=1, Bubble_IDEX=1, Stall=0, regardless of any hazard (wrong-path instruction is discarded).
REQ-025 MD start: state RUN, ID_isMD=1, Stall=0, EX_branchTaken=0 -> next edge: counter=MD_CYCLES-1, state MD_WAIT, MD_busy=1.
REQ-026 ID_isMD while stalled or flushed does not start the counter.
REQ-027 MD_WAIT: counter decrements by 1 every cycle, independent of stall and flush; the edge on which it reaches 0 returns state to RUN with MD_busy=0.
REQ-028 MD_busy is high for exactly MD_CYCLES-1 consecutive cycles after the start edge; an mfhi held in ID issues on the first cycle with MD_busy=0.
REQ-029 Counter width: $clog2(MD_CYCLES); decrement never wraps below 0.

Reset
REQ-030 Reset=1 at a rising edge -> state RUN, counter 0, MD_busy 0, regardless of prior state, including mid-MD_WAIT.
REQ-031 While Reset=1: Stall=0, Flush_IFID=0, Bubble_IDEX=0.

Configuration
REQ-032 Macro HAZARD_FORWARDING_EN selects the dependency policy.
REQ-033 Defined: only the load-use (REQ-021) and HI/LO (REQ-022) hazards stall; the datapath forwards from EX/MEM and MEM/WB.
REQ-034 Not defined: any RAW dependency on an EX or MEM writer also stalls.
REQ-035 The EX term of REQ-036 uses EX_regWrite and EX_rd in place of MEM_regWrite and MEM_rd.
REQ-036 No-forwarding hazard: MEM_regWrite & MEM_rd!=0 & (MEM_rd==ID_rs | (ID_usesRt & MEM_rd==ID_rt)).

Structure
REQ-037 Package mips_pipe_pkg holds the FSM state enum, the REG_ZERO constant (5'd0) and the MD_CYCLES default.
REQ-038 Sub-module md_busy_timer holds the counter and MD_busy register: inputs start and Reset, outputs busy and done.

Verification
REQ-039 lw $8 in EX, ID add uses rs=8 -> Stall=1 and Bubble_IDEX=1 for 1 cycle, then Stall=0.
REQ-040 lw $0 in EX, ID reads rs=0 -> Stall=0.
REQ-041 mult issues, mflo follows in ID, MD_CYCLES=4 -> MD_busy high 3 cycles, mflo stalled 3 cycles.
REQ-042 Load-use hazard plus EX_branchTaken=1 in the same cycle -> Stall=0, Flush_IFID=1, Bubble_IDEX=1.
REQ-043 Reset at counter=5 in MD_WAIT -> next cycle MD_busy=0, state RUN; mflo in ID issues without stall.
REQ-044 Without HAZARD_FORWARDING_EN: add $9 in MEM, ID reads rt=9 with ID_usesRt=1 -> Stall=1.
REQ-045 With HAZARD_FORWARDING_EN: same stimulus as REQ-044 -> Stall=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared types and constants for the MIPS pipeline hazard
//                logic: mult/div FSM state encoding, the hard-wired zero
//                register index and a RAW dependency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    // Mult/div tracking FSM: RUN = HI/LO valid, MD_WAIT = result pending
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_e;

    // Register $0 is hard-wired to zero and never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default execute latency of a mult/div before HI/LO can be read
    localparam int MD_CYCLES_DEFAULT = 32;

    // True when a writer of wr_rd produces a source the ID instruction reads
    function automatic logic raw_match(
        input logic       wr_en,
        input logic [4:0] wr_rd,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return wr_en && (wr_rd != REG_ZERO) &&
               ((wr_rd == id_rs) || (id_uses_rt && (wr_rd == id_rt)));
    endfunction

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : Down-counter tracking an in-flight mult/div. A start pulse
//                loads MD_CYCLES-1 and raises busy; busy drops on the edge
//                where the counter reaches zero. done flags that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer
    import mips_pipe_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int             c_CNT_W    = $clog2(MD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(MD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ZERO     = '0;

    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;
    logic               r_busy_q;
    logic               w_busy_d;

    // Next counter/busy: load on start, otherwise count down (saturating at 0)
    always_comb begin
        w_count_d = r_count_q;
        w_busy_d  = r_busy_q;
        if (start) begin
            w_count_d = c_LOAD_VAL;
            w_busy_d  = 1'b1;
        end else if (r_busy_q && (r_count_q != c_ZERO)) begin
            w_count_d = r_count_q - c_ONE;
            if (r_count_q == c_ONE) begin
                w_busy_d = 1'b0;
            end
        end
    end

    // Counter and busy registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count_q <= c_ZERO;
            r_busy_q  <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_busy_q && (r_count_q == c_ONE);

endmodule : md_busy_timer
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_controller
//  Description : ID-stage hazard detection for a 5-stage MIPS pipeline.
//                Generates Stall / Flush_IFID / Bubble_IDEX from load-use,
//                HI/LO (mult/div in flight) and, without forwarding, general
//                RAW dependencies on EX and MEM writers. A taken branch in EX
//                always wins: the wrong-path ID instruction is flushed.
//  Config      : HAZARD_FORWARDING_EN - when defined, only load-use and HI/LO
//                hazards stall (datapath forwards from EX/MEM and MEM/WB).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_controller
    import mips_pipe_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_usesRt,
    input  logic       ID_isMD,
    input  logic       ID_readsHiLo,
    input  logic [4:0] EX_rd,
    input  logic       EX_regWrite,
    input  logic       EX_memRead,
    input  logic [4:0] MEM_rd,
    input  logic       MEM_regWrite,
    input  logic       EX_branchTaken,
    output logic       Stall,
    output logic       Flush_IFID,
    output logic       Bubble_IDEX,
    output logic       MD_busy
);

    md_state_e r_state_q;
    md_state_e w_state_d;

    logic w_load_use;
    logic w_hilo;
    logic w_raw;
    logic w_hazard;
    logic w_md_start;
    logic w_md_busy;
    logic w_md_done;

    // Load in EX whose result the ID instruction needs: cannot be forwarded
    assign w_load_use = raw_match(EX_regWrite && EX_memRead, EX_rd,
                                  ID_rs, ID_rt, ID_usesRt);

    // HI/LO readers and new mult/div must wait for the pending result
    assign w_hilo = w_md_busy && (ID_readsHiLo || ID_isMD);

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers ordinary RAW dependencies; MEM-stage info is unused
    logic w_unused_mem;
    assign w_unused_mem = ^{MEM_rd, MEM_regWrite};
    assign w_raw        = 1'b0;
`else
    // No forwarding paths: any pending EX or MEM writer of a source stalls
    assign w_raw = raw_match(EX_regWrite,  EX_rd,  ID_rs, ID_rt, ID_usesRt) ||
                   raw_match(MEM_regWrite, MEM_rd, ID_rs, ID_rt, ID_usesRt);
`endif

    assign w_hazard = w_load_use || w_hilo || w_raw;

    // Pipeline control: taken branch flushes, otherwise a hazard stalls
    always_comb begin
        Stall       = 1'b0;
        Flush_IFID  = 1'b0;
        Bubble_IDEX = 1'b0;
        if (!Reset) begin
            if (EX_branchTaken) begin
                Flush_IFID  = 1'b1;
                Bubble_IDEX = 1'b1;
            end else if (w_hazard) begin
                Stall       = 1'b1;
                Bubble_IDEX = 1'b1;
            end
        end
    end

    // A mult/div only starts when it actually leaves ID this cycle
    assign w_md_start = (r_state_q == ST_RUN) && ID_isMD && !Stall &&
                        !EX_branchTaken && !Reset;

    // Next-state logic: wait in MD_WAIT until the timer expires
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_RUN:     if (w_md_start) w_state_d = ST_MD_WAIT;
            ST_MD_WAIT: if (w_md_done)  w_state_d = ST_RUN;
            default:    w_state_d = ST_RUN;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q <= ST_RUN;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .start (w_md_start),
        .busy  (w_md_busy),
        .done  (w_md_done)
    );

    assign MD_busy = w_md_busy;

endmodule : hazard_stall_controller
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_controller
//  Description : Directed self-checking bench for hazard_stall_controller.
//                Two instances share stimulus: MD_CYCLES=4 and MD_CYCLES=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] ID_rs, ID_rt, EX_rd, MEM_rd;
    logic       ID_usesRt, ID_isMD, ID_readsHiLo;
    logic       EX_regWrite, EX_memRead, MEM_regWrite, EX_branchTaken;

    logic Stall4, Flush4, Bubble4, Busy4;
    logic Stall8, Flush8, Bubble8, Busy8;

    int n_checks = 0;
    int n_errors = 0;

`ifdef HAZARD_FORWARDING_EN
    localparam logic c_RAW_STALL = 1'b0;
`else
    localparam logic c_RAW_STALL = 1'b1;
`endif

    always #5 Clk = ~Clk;

    hazard_stall_controller #(.MD_CYCLES(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_usesRt(ID_usesRt),
        .ID_isMD(ID_isMD), .ID_readsHiLo(ID_readsHiLo),
        .EX_rd(EX_rd), .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
        .MEM_rd(MEM_rd), .MEM_regWrite(MEM_regWrite),
        .EX_branchTaken(EX_branchTaken),
        .Stall(Stall4), .Flush_IFID(Flush4), .Bubble_IDEX(Bubble4),
        .MD_busy(Busy4)
    );

    hazard_stall_controller #(.MD_CYCLES(8)) u_dut8 (
        .Clk(Clk), .Reset(Reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_usesRt(ID_usesRt),
        .ID_isMD(ID_isMD), .ID_readsHiLo(ID_readsHiLo),
        .EX_rd(EX_rd), .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
        .MEM_rd(MEM_rd), .MEM_regWrite(MEM_regWrite),
        .EX_branchTaken(EX_branchTaken),
        .Stall(Stall8), .Flush_IFID(Flush8), .Bubble_IDEX(Bubble8),
        .MD_busy(Busy8)
    );

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_usesRt = 1'b0;
        ID_isMD = 1'b0; ID_readsHiLo = 1'b0;
        EX_rd = 5'd0; EX_regWrite = 1'b0; EX_memRead = 1'b0;
        MEM_rd = 5'd0; MEM_regWrite = 1'b0; EX_branchTaken = 1'b0;
    endtask

    task automatic check_ctl4(input string tag, input logic s, input logic f,
                              input logic b);
        check_value({tag, "_stall"},  32'(Stall4),  32'(s));
        check_value({tag, "_flush"},  32'(Flush4),  32'(f));
        check_value({tag, "_bubble"}, 32'(Bubble4), 32'(b));
    endtask

    task automatic load_ex(input logic [4:0] rd);
        EX_rd = rd; EX_regWrite = 1'b1; EX_memRead = 1'b1;
    endtask

    // Watchdog: never let the run hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        clear_inputs();
        Reset = 1'b1;
        // Hazard present while in reset: outputs must stay quiet
        load_ex(5'd8); ID_rs = 5'd8; EX_branchTaken = 1'b0;
        step(); step();
        check_ctl4("rst_outs", 1'b0, 1'b0, 1'b0);
        check_value("rst_busy4", 32'(Busy4), 32'd0);
        check_value("rst_busy8", 32'(Busy8), 32'd0);
        Reset = 1'b0;
        clear_inputs();
        #1;
        check_ctl4("idle", 1'b0, 1'b0, 1'b0);

        // lw $8 in EX, ID reads rs=8: one stall cycle, then clear
        load_ex(5'd8); ID_rs = 5'd8; #1;
        check_ctl4("lu_rs", 1'b1, 1'b0, 1'b1);
        step();
        clear_inputs(); #1;
        check_ctl4("lu_after", 1'b0, 1'b0, 1'b0);

        // lw $0: never a hazard
        load_ex(5'd0); ID_rs = 5'd0; ID_rt = 5'd0; ID_usesRt = 1'b1; #1;
        check_value("lu_r0", 32'(Stall4), 32'd0);

        // rt matches only count when the ID instruction reads rt
        clear_inputs(); load_ex(5'd12); ID_rs = 5'd3; ID_rt = 5'd12; #1;
        check_value("lu_rt_unused", 32'(Stall4), 32'd0);
        ID_usesRt = 1'b1; #1;
        check_value("lu_rt_used", 32'(Stall4), 32'd1);

        // Load-use plus taken branch: flush wins
        EX_branchTaken = 1'b1; #1;
        check_ctl4("lu_branch", 1'b0, 1'b1, 1'b1);

        // Plain taken branch, no hazard
        clear_inputs(); EX_branchTaken = 1'b1; #1;
        check_ctl4("branch", 1'b0, 1'b1, 1'b1);

        // add $9 in MEM, ID reads rt=9
        clear_inputs(); MEM_regWrite = 1'b1; MEM_rd = 5'd9;
        ID_rt = 5'd9; ID_usesRt = 1'b1; #1;
        check_value("raw_mem_rt", 32'(Stall4), 32'(c_RAW_STALL));
        MEM_rd = 5'd0; ID_rt = 5'd0; #1;
        check_value("raw_mem_r0", 32'(Stall4), 32'd0);

        // Non-load writer in EX, ID reads rs
        clear_inputs(); EX_regWrite = 1'b1; EX_rd = 5'd17; ID_rs = 5'd17; #1;
        check_value("raw_ex_rs", 32'(Stall4), 32'(c_RAW_STALL));

        // mult while flushed or stalled does not start the timer
        clear_inputs(); ID_isMD = 1'b1; EX_branchTaken = 1'b1; step();
        check_value("md_nostart_flush", 32'(Busy4), 32'd0);
        EX_branchTaken = 1'b0; load_ex(5'd4); ID_rs = 5'd4; step();
        check_value("md_nostart_stall", 32'(Busy4), 32'd0);

        // mult issues, mflo follows: MD_CYCLES=4 -> 3 busy/stall cycles
        clear_inputs(); ID_isMD = 1'b1; #1;
        check_value("md_issue_stall", 32'(Stall4), 32'd0);
        step();
        ID_isMD = 1'b0; ID_readsHiLo = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            check_value("md_busy_wait", 32'(Busy4), 32'd1);
            check_ctl4("md_mflo_wait", 1'b1, 1'b0, 1'b1);
            step();
        end
        check_value("md_busy_done", 32'(Busy4), 32'd0);
        check_value("md_mflo_issue", 32'(Stall4), 32'd0);

        // Clean slate for the 8-cycle instance
        Reset = 1'b1; step(); Reset = 1'b0;

        // Reset mid-MD_WAIT with counter at 5 (MD_CYCLES=8)
        clear_inputs(); ID_isMD = 1'b1; #1;
        step();                                   // counter = 7
        ID_isMD = 1'b0; ID_readsHiLo = 1'b1; #1;
        check_value("md8_busy", 32'(Busy8), 32'd1);
        check_value("md8_stall", 32'(Stall8), 32'd1);
        EX_branchTaken = 1'b1; #1;
        check_value("md8_branch_stall", 32'(Stall8), 32'd0);
        check_value("md8_branch_flush", 32'(Flush8), 32'd1);
        EX_branchTaken = 1'b0;
        step(); step();                           // counter = 5
        check_value("md8_busy_c5", 32'(Busy8), 32'd1);
        Reset = 1'b1; #1;
        check_value("md8_rst_stall", 32'(Stall8), 32'd0);
        step();
        Reset = 1'b0; #1;
        check_value("md8_rst_busy", 32'(Busy8), 32'd0);
        check_value("md8_rst_mflo", 32'(Stall8), 32'd0);
        check_value("md4_rst_busy", 32'(Busy4), 32'd0);

        // Full busy duration on MD_CYCLES=8: mfhi stalls exactly 7 cycles
        clear_inputs(); ID_isMD = 1'b1; #1;
        step();
        ID_isMD = 1'b0; ID_readsHiLo = 1'b1; #1;
        n = 0;
        while (Stall8 && n < 20) begin
            n++;
            step();
        end
        check_value("md8_stall_len", 32'(n), 32'd7);
        check_value("md8_busy_end", 32'(Busy8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_stall_controller
`default_nettype wire
